axi_write_sched: RTL
====================

AXI_WRITE_SCHED -- requirements
Module: axi_write_sched

Interface
REQ-001 The block SHALL have one clock, clk_i, and an asynchronous active-low reset, rst_ni.
REQ-002 The block SHALL have parameter ADDR_W, default 32, meaning the AW address width.
REQ-003 clk_i  input  1  clock; every flop SHALL be clocked on the rising edge.
REQ-004 rst_ni  input  1  asynchronous active-low reset.
REQ-005 awvalid  input  1  master AW valid.
REQ-006 awready  output  1  master AW ready.
REQ-007 awaddr  input  ADDR_W  master AW address; bits [ADDR_W-1:ADDR_W-4] select the region.
REQ-008 awlen  input  8  burst length minus one.
REQ-009 s_awvalid  output  4  per-slave AW valid, one-hot or zero.
REQ-010 s_awready  input  4  per-slave AW ready.
REQ-011 s_wsel  output  4  W-mux select: 4'h0-4'h3 selects a slave, 4'hF selects none.
REQ-012 wvalid  input  1  master W valid, observed in parallel with the W mux.
REQ-013 wready  input  1  muxed W ready returned by the W mux.
REQ-014 wlast  input  1  master W last.
REQ-015 err_wready  output  1  W ready used for decode-error beats; it is ORed externally with the mux wready.
REQ-016 s_bvalid  input  4  per-slave B valid.
REQ-017 s_bresp  input  8  per-slave B response; slave n occupies bits [2n+1:2n].
REQ-018 s_bready  output  4  per-slave B ready.
REQ-019 bvalid  output  1  master B valid.
REQ-020 bresp  output  2  master B response.
REQ-021 bready  input  1  master B ready.

Function
REQ-022 The block SHALL use a state machine with states IDLE, AW, W, B, ERR_AW, ERR_W and ERR_B, and SHALL process one write transaction at a time.
REQ-023 IDLE: on awvalid=1, the block SHALL latch sel = region bits and latch awlen; region 0-3 SHALL transition to AW, and any other region SHALL transition to ERR_AW; awready SHALL be 0 in IDLE.
REQ-024 AW: s_awvalid[sel]=1 and awready=s_awready[sel]; on awvalid&awready the block SHALL clear the beat counter and transition to W.
REQ-025 W: s_wsel=sel, and the selection SHALL be held stable for the whole burst; each wvalid&wready cycle SHALL increment the 9-bit beat counter; wvalid&wready&wlast SHALL transition to B.
REQ-026 At the wlast handshake, if beats (including the last beat) differ from awlen+1, the block SHALL set a sticky len_err flag.
REQ-027 B: s_bready[sel]=bready, bvalid=s_bvalid[sel] and bresp=s_bresp[sel].
REQ-028 In B, if len_err=1 and the slave response is 2'b00, bresp SHALL be forced to 2'b10.
REQ-029 In B, s_bvalid[sel]&bready SHALL transition to IDLE and clear len_err.
REQ-030 ERR_AW: awready=1 for exactly one cycle, then the block SHALL transition to ERR_W.
REQ-031 ERR_W: s_wsel=4'hF and err_wready=1; each wvalid beat SHALL be counted; wvalid&wlast SHALL transition to ERR_B.
REQ-032 ERR_B: bvalid=1 and bresp=2'b11; on bready the block SHALL transition to IDLE.
REQ-033 s_wsel SHALL equal 4'hF in every state except W.
REQ-034 s_awvalid, s_bready and err_wready SHALL be 0 outside the states that drive them.
REQ-035 A new AW SHALL NOT be accepted until the B handshake of the current transaction completes.
REQ-036 Master W beats presented before the AW handshake SHALL stall, because wready is 0 while s_wsel=4'hF.
REQ-037 s_bvalid from a non-selected slave SHALL be ignored and left unacknowledged.
REQ-038 The beat counter SHALL saturate at 9'h1FF, and saturation SHALL set len_err.
REQ-039 wlast on the first beat with awlen=0 SHALL be a legal single-beat burst.
REQ-040 All outputs SHALL be registered-state decodes with no combinational path from awaddr to awready.
REQ-041 The only combinational paths permitted are s_awready→awready, s_bvalid/s_bresp→bvalid/bresp, and bready→s_bready.

Reset
REQ-042 rst_ni=0 SHALL, asynchronously at any time, force the state to IDLE, s_wsel=4'hF, all other outputs to 0, and clear the counter, sel and len_err.
REQ-043 Reset asserted mid-burst SHALL abandon the transaction, and the block SHALL emit no B response for it.
REQ-044 After rst_ni deasserts, the first awvalid SHALL be sampled on the next rising edge.

Verification
REQ-045 Single beat: awaddr=0x2000_0000, awlen=0, slave 2 ready, one W beat with wlast, s_bresp slot2=00 -> s_awvalid=4'b0100, s_wsel=4'h2 only during W, bresp=00.
REQ-046 Four-beat burst with stalls: awaddr=0x1xxx_xxxx, awlen=3, wready toggling -> s_wsel held at 4'h1 for all 4 beats, transition to B on the 4th beat, bresp passes through the slave value.
REQ-047 Decode error: awaddr=0x8000_0000, awlen=1, two beats -> awready pulses once, err_wready=1 for both beats, s_wsel=4'hF throughout, bvalid with bresp=11.
REQ-048 Length mismatch: awlen=3 with wlast on beat 2, slave bresp=00 -> bresp=10; the next transaction returns 00.
REQ-049 Reset mid-burst: rst_ni=0 after beat 1 of a 4-beat burst to slave 3 -> s_wsel=4'hF and s_awvalid=0 immediately; the next transaction to slave 0 completes normally.
REQ-050 Back-to-back: a second awvalid held during B -> awready=0 until the B handshake, then AW is accepted for the new slave.

Source files
------------

// File: rtl/axi_write_sched.sv
// AXI write-channel scheduler: decodes the AW region, routes one write
// transaction at a time to one of four slaves and answers decode errors locally.
module axi_write_sched #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              awvalid,
  output logic              awready,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic [7:0]        awlen,
  output logic [3:0]        s_awvalid,
  input  logic [3:0]        s_awready,
  output logic [3:0]        s_wsel,
  input  logic              wvalid,
  input  logic              wready,
  input  logic              wlast,
  output logic              err_wready,
  input  logic [3:0]        s_bvalid,
  input  logic [7:0]        s_bresp,
  output logic [3:0]        s_bready,
  output logic              bvalid,
  output logic [1:0]        bresp,
  input  logic              bready
);

  localparam int unsigned CNT_W = 9;
  localparam int unsigned SEL_W = 2;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_AW     = 3'd1;
  localparam logic [2:0] ST_W      = 3'd2;
  localparam logic [2:0] ST_B      = 3'd3;
  localparam logic [2:0] ST_ERR_AW = 3'd4;
  localparam logic [2:0] ST_ERR_W  = 3'd5;
  localparam logic [2:0] ST_ERR_B  = 3'd6;

  logic [2:0]       state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [7:0]       len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             len_err_q, len_err_d;

  logic [3:0]       region_c;
  logic [CNT_W-1:0] cnt_inc_c;
  logic [CNT_W-1:0] exp_beats_c;
  logic [1:0]       slv_resp_c;
  logic             unused_addr_c;

  assign region_c      = awaddr[ADDR_W-1 -: 4];
  assign unused_addr_c = ^awaddr[ADDR_W-5:0];
  // Beat counter pins at all-ones instead of wrapping.
  assign cnt_inc_c     = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
  assign exp_beats_c   = CNT_W'(len_q) + CNT_W'(1);
  assign slv_resp_c    = s_bresp[{sel_q, 1'b0} +: 2];

  // State and transaction context registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      len_err_q <= len_err_d;
    end
  end

  // Next-state, beat counting and length-error tracking.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    len_err_d = len_err_q;
    case (state_q)
      ST_IDLE: begin
        if (awvalid) begin
          sel_d   = region_c[1:0];
          len_d   = awlen;
          state_d = (region_c[3:2] == 2'b00) ? ST_AW : ST_ERR_AW;
        end
      end
      ST_AW: begin
        if (awvalid && s_awready[sel_q]) begin
          cnt_d   = '0;
          state_d = ST_W;
        end
      end
      ST_W: begin
        if (wvalid && wready) begin
          cnt_d = cnt_inc_c;
          if (cnt_inc_c == {CNT_W{1'b1}}) len_err_d = 1'b1;
          if (wlast) begin
            if (cnt_inc_c != exp_beats_c) len_err_d = 1'b1;
            state_d = ST_B;
          end
        end
      end
      ST_B: begin
        if (s_bvalid[sel_q] && bready) begin
          len_err_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      ST_ERR_AW: begin
        cnt_d   = '0;
        state_d = ST_ERR_W;
      end
      ST_ERR_W: begin
        if (wvalid) begin
          cnt_d = cnt_inc_c;
          if (wlast) state_d = ST_ERR_B;
        end
      end
      ST_ERR_B: begin
        if (bready) begin
          len_err_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from registered state; only handshake inputs pass through.
  always_comb begin
    awready    = 1'b0;
    s_awvalid  = 4'h0;
    s_wsel     = 4'hF;
    err_wready = 1'b0;
    s_bready   = 4'h0;
    bvalid     = 1'b0;
    bresp      = 2'b00;
    case (state_q)
      ST_AW: begin
        s_awvalid = 4'b0001 << sel_q;
        awready   = s_awready[sel_q];
      end
      ST_W: s_wsel = 4'(sel_q);
      ST_B: begin
        s_bready = bready ? (4'b0001 << sel_q) : 4'h0;
        bvalid   = s_bvalid[sel_q];
        bresp    = (len_err_q && slv_resp_c == 2'b00) ? 2'b10 : slv_resp_c;
      end
      ST_ERR_AW: awready = 1'b1;
      ST_ERR_W:  err_wready = 1'b1;
      ST_ERR_B: begin
        bvalid = 1'b1;
        bresp  = 2'b11;
      end
      default: ;
    endcase
  end

endmodule
